sort_scheduler: RTL



---
 rtl/sort_scheduler_pkg.sv | 18 +
 rtl/sort_scheduler_cmp.sv | 26 ++
 rtl/sort_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sort_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// sort_scheduler_pkg : shared state encoding and default sizes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sort_scheduler_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 3;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sort_scheduler_cmp.sv
// ----------------------------------------------------------------------------
// cmp_minmax : combinational unsigned compare producing the ordered pair
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_minmax
  import sort_scheduler_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         gt
);

  // Strict compare: equal operands keep their order.
  assign gt = (a > b);
  assign lo = gt ? b : a;
  assign hi = gt ? a : b;

endmodule

`default_nettype wire

// File: rtl/sort_scheduler.sv
// ----------------------------------------------------------------------------
// sort_scheduler : load N values, early-exit bubble sort, stream out ascending
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sort_scheduler
  import sort_scheduler_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] LAST_P   = CW'(N - 2);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  bank_q [N];
  logic [W-1:0]  bank_d [N];
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] p_q, p_d;
  logic [CW-1:0] i_q, i_d;
  logic          swapped_q, swapped_d;

  logic [W-1:0]  cmp_a, cmp_b, cmp_lo, cmp_hi, rd_val;
  logic          cmp_gt, swapped_now;
  logic [CW-1:0] last_i;

  always_comb begin
    cmp_a  = '0;
    cmp_b  = '0;
    rd_val = '0;
    for (int k = 0; k < N; k++) begin
      if (CW'(k) == i_q)             cmp_a  = bank_q[k];
      if (CW'(k) == i_q + CW'(1))    cmp_b  = bank_q[k];
      if (CW'(k) == rd_cnt_q)        rd_val = bank_q[k];
    end
  end

  cmp_minmax #(.W(W)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lo (cmp_lo),
    .hi (cmp_hi),
    .gt (cmp_gt)
  );

  // Each pass bubbles the largest remaining value to the end, so it shrinks by one.
  assign last_i      = LAST_P - p_q;
  assign swapped_now = swapped_q | cmp_gt;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    p_d       = p_q;
    i_d       = i_q;
    swapped_d = swapped_q;
    for (int k = 0; k < N; k++) bank_d[k] = bank_q[k];

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++)
            if (CW'(k) == wr_cnt_q) bank_d[k] = in_data;
          if (wr_cnt_q == LAST_IDX) begin
            state_d   = S_SORT;
            wr_cnt_d  = '0;
            p_d       = '0;
            i_d       = '0;
            swapped_d = 1'b0;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      S_SORT: begin
        for (int k = 0; k < N; k++) begin
          if (CW'(k) == i_q)               bank_d[k] = cmp_lo;
          else if (CW'(k) == i_q + CW'(1)) bank_d[k] = cmp_hi;
        end
        if (i_q != last_i) begin
          i_d       = i_q + CW'(1);
          swapped_d = swapped_now;
        end else if (p_q == LAST_P || !swapped_now) begin
          state_d   = S_OUT;
          rd_cnt_d  = '0;
          p_d       = '0;
          i_d       = '0;
          swapped_d = 1'b0;
        end else begin
          p_d       = p_q + CW'(1);
          i_d       = '0;
          swapped_d = 1'b0;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            state_d  = S_LOAD;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      p_q       <= '0;
      i_q       <= '0;
      swapped_q <= 1'b0;
      for (int k = 0; k < N; k++) bank_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      p_q       <= p_d;
      i_q       <= i_d;
      swapped_q <= swapped_d;
      for (int k = 0; k < N; k++) bank_q[k] <= bank_d[k];
    end
  end

  // Outputs depend only on registered state, never on out_ready.
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_SORT);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? rd_val : '0;

endmodule

`default_nettype wire
